// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the 32x32 register bank and its write-port arbiter.
// Arbitration policy is chosen by REG_WR_RR_EN in reg_wr_arbiter.
package reg_bank_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_COUNT  = 32;

    // Bit 0 of this register is the bank's program_done flag
    localparam logic [REG_ADDR_W-1:0] DONE_REG = 5'd30;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } reg_wr_t;

endpackage

// File: rtl/reg_wr_arbiter_rr_pick.sv
// Combinational one-hot picker: first set request at or after 'start', wrapping modulo N.
// A start of 0 degenerates to fixed lowest-index-first priority.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    int unsigned s;
    int unsigned pos;
    logic        found;

    // Walk the rotated order; constant bit indices keep the select logic flat
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        found   = 1'b0;
        pos     = 0;
        s       = 32'(start);
        for (int unsigned k = 0; k < N; k++) begin
            pos = s + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i] && (pos == i)) begin
                    found      = 1'b1;
                    grant_c[i] = 1'b1;
                    idx_c      = IDX_W'(i);
                end
            end
        end
        any_c = found;
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Write-port arbiter for the register bank: one registered write per cycle, frozen after program_done.
// Define REG_WR_RR_EN for round-robin arbitration; otherwise fixed priority (index 0 highest).
module reg_wr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [REG_ADDR_W*NUM_REQ-1:0]   req_addr,
    input  logic [REG_DATA_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            program_done,
    output logic                            RegWrite,
    output logic [REG_ADDR_W-1:0]           write_register,
    output logic [REG_DATA_W-1:0]           write_data,
    output logic                            halted,
    output logic [CNT_W-1:0]                wr_count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic               grant_en_c;
    logic [NUM_REQ-1:0] pick_req_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [IDX_W-1:0]   start_c;
    logic               pick_any_c;
    reg_wr_t            sel_wr_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // HALT is terminal; grants only while running and the bank has not signalled done
    always_comb begin
        state_nxt  = state;
        grant_en_c = 1'b0;
        case (state)
            RUN: begin
                grant_en_c = !program_done;
                if (program_done) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
        endcase
    end

    assign pick_req_c = req_valid & {NUM_REQ{grant_en_c}};

`ifdef REG_WR_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (pick_any_c) begin
            rr_ptr <= (pick_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);
        end
    end

    assign start_c = rr_ptr;
`else
    assign start_c = '0;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (pick_req_c),
        .start   (start_c),
        .grant_c (grant_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    assign req_ready = grant_c;

    always_comb begin
        sel_wr_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_c == IDX_W'(i)) begin
                sel_wr_c.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel_wr_c.data = req_data[i*REG_DATA_W +: REG_DATA_W];
            end
        end
    end

    // Address/data hold on idle cycles; only RegWrite pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite       <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            wr_count       <= '0;
            halted         <= 1'b0;
        end else begin
            RegWrite <= pick_any_c;
            halted   <= (state_nxt == HALT);
            if (pick_any_c) begin
                write_register <= sel_wr_c.addr;
                write_data     <= sel_wr_c.data;
            end
            if (pick_any_c && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter with a behavioural register bank driving program_done.
// Expectations follow REG_WR_RR_EN when it is defined.
module tb_reg_wr_arbiter;
    import reg_bank_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned CW = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [5*N-1:0]       req_addr;
    logic [32*N-1:0]      req_data;
    logic [N-1:0]         req_ready;
    logic                 program_done;
    logic                 RegWrite;
    logic [4:0]           write_register;
    logic [31:0]          write_data;
    logic                 halted;
    logic [CW-1:0]        wr_count;

    logic [4:0]           ra [N];
    logic [31:0]          rd [N];
    logic [31:0]          bank [32];

    reg_wr_t              q [$];
    reg_wr_t              mon_e;
    reg_wr_t              push_e;
    int                   total = 0;
    int                   bad = 0;
    logic                 m_halt = 1'b0;
    logic [CW-1:0]        m_cnt = '0;
    logic                 pend = 1'b0;
    logic                 pd_sample = 1'b0;
    logic [N-1:0]         exp_tab [6];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*5 +: 5]   = ra[i];
            req_data[i*32 +: 32] = rd[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) bank[i] <= '0;
        end else if (RegWrite) begin
            bank[write_register] <= write_data;
        end
    end
    assign program_done = bank[30][0];

    reg_wr_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .program_done   (program_done),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .halted         (halted),
        .wr_count       (wr_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every registered write must match the oldest expected handshake
    always @(negedge clk) begin
        if (!reset) begin
            check("halted", 64'(halted), 64'(m_halt));
            check("wr_count", 64'(wr_count), 64'(m_cnt));
            if (RegWrite) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none", write_register, write_data);
                end else begin
                    mon_e = q.pop_front();
                    check("write_register", 64'(write_register), 64'(mon_e.addr));
                    check("write_data", 64'(write_data), 64'(mon_e.data));
                end
            end
        end
    end

    // One clock of stimulus with a hand-computed expected grant vector
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] exp_rdy);
        @(posedge clk);
        if (pend && (m_cnt != '1)) m_cnt = m_cnt + CW'(1);
        pend = 1'b0;
        if (pd_sample) m_halt = 1'b1;
        #1 req_valid = v;
        #1 check("req_ready", 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                push_e.addr = ra[i];
                push_e.data = rd[i];
                q.push_back(push_e);
                pend = 1'b1;
            end
        end
        pd_sample = program_done;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        q.delete();
        m_cnt = '0;
        m_halt = 1'b0;
        pend = 1'b0;
        pd_sample = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
`ifdef REG_WR_RR_EN
        exp_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_tab = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end

        // Power-on reset values
        #1 reset = 1'b1;
        #2;
        check("init_regwrite", 64'(RegWrite), 64'd0);
        check("init_write_register", 64'(write_register), 64'd0);
        check("init_write_data", 64'(write_data), 64'd0);
        check("init_wr_count", 64'(wr_count), 64'd0);
        check("init_halted", 64'(halted), 64'd0);
        check("init_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single write and bank commit latency
        ra[0] = 5'd5;
        rd[0] = 32'hDEADBEEF;
        cycle(3'b001, 3'b001);
        cycle(3'b000, 3'b000);
        check("r5_before_commit", 64'(bank[5]), 64'd0);
        cycle(3'b000, 3'b000);
        check("r5_after_commit", 64'(bank[5]), 64'hDEADBEEF);

        // Asynchronous reset while a grant and a registered write are active
        cycle(3'b001, 3'b001);
        cycle(3'b001, 3'b001);
        check("pre_reset_regwrite", 64'(RegWrite), 64'd1);
        pulse_reset();

        // Contention on all three requesters, then requester 0 drops out
        ra[0] = 5'd0;  rd[0] = 32'hA000_0000;
        ra[1] = 5'd1;  rd[1] = 32'hB111_1111;
        ra[2] = 5'd2;  rd[2] = 32'hC222_2222;
        for (int i = 0; i < 6; i++) cycle(3'b111, exp_tab[i]);
        cycle(3'b110, 3'b010);
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);
        check("r0_written", 64'(bank[0]), 64'hA000_0000);
        check("r1_written", 64'(bank[1]), 64'hB111_1111);
`ifdef REG_WR_RR_EN
        check("r2_written", 64'(bank[2]), 64'hC222_2222);
`else
        check("r2_untouched", 64'(bank[2]), 64'd0);
`endif

        // r30 <- 1 ends the program; a write registered just before halt still lands,
        // and a request in the same cycle as program_done is refused
        ra[2] = 5'd30; rd[2] = 32'h1;
        ra[0] = 5'd7;  rd[0] = 32'h77;
        ra[1] = 5'd9;  rd[1] = 32'h99;
        cycle(3'b100, 3'b100);
        cycle(3'b001, 3'b001);
        cycle(3'b010, 3'b000);
        for (int i = 0; i < 5; i++) cycle(3'b111, 3'b000);
        req_valid = '0;
        check("r30_done", 64'(bank[30]), 64'h1);
        check("r7_late_write", 64'(bank[7]), 64'h77);
        check("r9_untouched", 64'(bank[9]), 64'd0);
        check("halt_wr_count", 64'(wr_count), 64'd9);

        // Counter saturation
        pulse_reset();
        ra[0] = 5'd4;
        rd[0] = 32'h5A5A_0000;
        for (int i = 0; i < 20; i++) cycle(3'b001, 3'b001);
        cycle(3'b000, 3'b000);
        cycle(3'b000, 3'b000);
        check("sat_wr_count", 64'(wr_count), 64'hF);
        check("sat_r4", 64'(bank[4]), 64'h5A5A_0000);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
